// File: rtl/reaction_capture.sv
// reaction_capture: timing front-end of the reaction-time game.
// Runs the pre-go delay, lights the GO LED, timestamps GO and the press in
// milliseconds, and latches the external subtractor's difference as the
// reaction time together with false-start / timeout status.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// DELAY | counting down the pre-go delay; any button level is a false start
// GO    | LED lit, elapsed ms counting, waiting for a press edge
// CALC  | single cycle in which the subtractor result is captured
// DONE  | result and flags held until the next start
module reaction_capture #(
  parameter int WIDTH    = 13,
  parameter int TICK_DIV = 50000,
  parameter int MAX_MS   = 8191
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             button,
  input  logic [WIDTH-1:0] delay_ms,
  input  logic [WIDTH-1:0] sub_s,
  input  logic             sub_ovf,
  output logic [WIDTH-1:0] sub_x,
  output logic [WIDTH-1:0] sub_y,
  output logic             sub_addsub,
  output logic             led_go,
  output logic             busy,
  output logic [WIDTH-1:0] result_ms,
  output logic             result_valid,
  output logic             false_start,
  output logic             timeout,
  output logic             ovf_flag
);

  localparam int               PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ECNT_LAST = WIDTH'(MAX_MS - 1);
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_GO,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    pre;
  logic [WIDTH-1:0] ts;
  logic [WIDTH-1:0] dcnt;
  logic [WIDTH-1:0] ecnt;
  logic             button_q;
  logic             tick;
  logic             press;
  logic             accept;
  logic             go_enter;
  logic             take_press;
  logic             fs_set;
  logic             to_set;

  assign tick       = (pre == PRE_LAST);
  assign press      = button & ~button_q;
  assign accept     = start & ((state == S_IDLE) | (state == S_DONE));
  assign sub_addsub = 1'b1;
  assign led_go     = (state == S_GO);
  assign busy       = (state == S_DELAY) | (state == S_GO) | (state == S_CALC);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state and per-transition strobes; a button level in DELAY outranks expiry,
  // a press edge in GO outranks the timeout tick
  always_comb begin
    state_nx   = state;
    go_enter   = 1'b0;
    take_press = 1'b0;
    fs_set     = 1'b0;
    to_set     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_DELAY;
      S_DELAY: begin
        if (button) begin
          state_nx = S_DONE;
          fs_set   = 1'b1;
        end else if (tick && dcnt == ONE) begin
          state_nx = S_GO;
          go_enter = 1'b1;
        end
      end
      S_GO: begin
        if (press) begin
          state_nx   = S_CALC;
          take_press = 1'b1;
        end else if (tick && ecnt == ECNT_LAST) begin
          state_nx = S_DONE;
          to_set   = 1'b1;
        end
      end
      S_CALC:  state_nx = S_DONE;
      S_DONE:  if (start) state_nx = S_DELAY;
      default: state_nx = S_IDLE;
    endcase
  end

  // ms prescaler (re-phased on every accepted start) and free-running timestamp
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre      <= '0;
      ts       <= '0;
      button_q <= 1'b0;
    end else begin
      if (accept || tick) pre <= '0;
      else                pre <= pre + PW'(1);
      if (tick) ts <= ts + ONE;
      button_q <= button;
    end
  end

  // Delay down-counter (zero delay treated as 1 ms) and elapsed counter in GO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dcnt <= '0;
      ecnt <= '0;
    end else begin
      if (accept)                         dcnt <= (delay_ms == '0) ? ONE : delay_ms;
      else if (state == S_DELAY && tick)  dcnt <= dcnt - ONE;
      if (go_enter)                       ecnt <= '0;
      else if (state == S_GO && tick)     ecnt <= ecnt + ONE;
    end
  end

  // Timestamps handed to the subtractor; GO stamp is the post-tick value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_x <= '0;
      sub_y <= '0;
    end else begin
      if (go_enter)   sub_y <= ts + ONE;
      if (take_press) sub_x <= ts;
    end
  end

  // Result and status flags; cleared by the start that opens the next round
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_ms    <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
      ovf_flag     <= 1'b0;
    end else if (accept) begin
      result_ms    <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
      ovf_flag     <= 1'b0;
    end else if (fs_set) begin
      false_start <= 1'b1;
    end else if (to_set) begin
      timeout   <= 1'b1;
      result_ms <= MAX_VAL;
    end else if (state == S_CALC) begin
      result_ms    <= sub_s;
      ovf_flag     <= sub_ovf;
      result_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reaction_capture.sv
// Testbench for reaction_capture: randomized rounds checked against a
// millisecond-timeline model (timestamp derived arithmetically from cycle count).
module tb_reaction_capture;
  localparam int W     = 13;
  localparam int TD    = 4;
  localparam int MAXMS = 100;
  localparam int MOD   = 1 << W;

  logic         clk = 1'b0;
  logic         reset_n, start, button;
  logic [W-1:0] delay_ms, sub_s, sub_x, sub_y, result_ms;
  logic         sub_ovf, sub_addsub, led_go, busy, result_valid, false_start, timeout, ovf_flag;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base_k   = 0;
  int base_ts  = 0;

  always #5 clk = ~clk;

  reaction_capture #(.WIDTH(W), .TICK_DIV(TD), .MAX_MS(MAXMS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .button(button), .delay_ms(delay_ms),
    .sub_s(sub_s), .sub_ovf(sub_ovf), .sub_x(sub_x), .sub_y(sub_y), .sub_addsub(sub_addsub),
    .led_go(led_go), .busy(busy), .result_ms(result_ms), .result_valid(result_valid),
    .false_start(false_start), .timeout(timeout), .ovf_flag(ovf_flag)
  );

  // Downstream add/subtract unit
  assign sub_s   = sub_addsub ? (sub_x - sub_y) : (sub_x + sub_y);
  assign sub_ovf = sub_addsub ? ((sub_x[W-1] != sub_y[W-1]) && (sub_s[W-1] != sub_x[W-1]))
                              : ((sub_x[W-1] == sub_y[W-1]) && (sub_s[W-1] != sub_x[W-1]));

  // Timestamp value after edge k: ms elapsed since the last prescaler re-phase
  function automatic int ms_at(input int k);
    return (base_ts + (k - base_k) / TD) % MOD;
  endfunction

  function automatic int diff(input int x, input int y);
    return (x - y + MOD) % MOD;
  endfunction

  function automatic int ovf_model(input int x, input int y);
    int s;
    s = diff(x, y);
    return (((x >= MOD / 2) != (y >= MOD / 2)) && ((s >= MOD / 2) != (x >= MOD / 2))) ? 1 : 0;
  endfunction

  function automatic int dly(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start(input int d, output int ks);
    int t;
    start = 1'b1;
    delay_ms = W'(d);
    step();
    start = 1'b0;
    ks = cyc;
    t = ms_at(ks);
    base_k = ks;
    base_ts = t;
  endtask

  task automatic wait_ms(input int target);
    for (int i = 0; i < 40000 && ms_at(cyc + 1) != target; i++) step();
  endtask

  // One round: start, wait for GO, press p cycles after GO (p=0: no press)
  task automatic play(input int d, input int p, output int ks, output int go_k,
                      output int end_k, output int early_v);
    do_start(d, ks);
    go_k = -1;
    end_k = -1;
    early_v = 0;
    for (int i = 0; i < 1000 && go_k < 0; i++) begin
      if (led_go) go_k = cyc;
      else step();
    end
    if (go_k >= 0 && p > 0) begin
      while (cyc < go_k + p - 1) step();
      button = 1'b1;
      step();
      early_v = int'(result_valid);
      step();
      button = 1'b0;
      end_k = cyc;
    end else begin
      for (int i = 0; i < 1000 && busy; i++) step();
      end_k = cyc;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; button = 1'b0; delay_ms = '0;
    step(); step();
    n_checks++; if ({led_go, busy, result_valid, false_start, timeout, ovf_flag, sub_addsub} !== 7'b0000001) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000001", {led_go, busy, result_valid, false_start, timeout, ovf_flag, sub_addsub}); end
    n_checks++; if ({sub_x, sub_y, result_ms} !== '0) begin
      n_fail++; $display("FAIL reset_values: got x=%0d y=%0d r=%0d expected all 0", sub_x, sub_y, result_ms); end
    reset_n = 1'b1;
    cyc = 0; base_k = 0; base_ts = 0;
  endtask

  task automatic test_normal();
    int ks, g, e, ey, ex, er, ev, go_k, end_k;
    play(3, 101, ks, go_k, end_k, ev);
    g = ks + TD * 3; e = go_k + 101; ey = ms_at(g); ex = ms_at(e - 1); er = diff(ex, ey);
    n_checks++; if (go_k !== g) begin n_fail++; $display("FAIL normal_go_time: got cycle %0d expected %0d", go_k, g); end
    n_checks++; if (ev !== 0) begin n_fail++; $display("FAIL normal_latency: valid one cycle after press got %0d expected 0", ev); end
    n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL normal_valid: got %0d expected 1", result_valid); end
    n_checks++; if (result_ms !== er) begin n_fail++; $display("FAIL normal_result: got %0d expected %0d", result_ms, er); end
    n_checks++; if (sub_y !== ey || sub_x !== ex) begin n_fail++; $display("FAIL normal_stamps: got x=%0d y=%0d expected x=%0d y=%0d", sub_x, sub_y, ex, ey); end
    n_checks++; if ({false_start, timeout, busy, led_go} !== 4'b0000) begin n_fail++; $display("FAIL normal_flags: got %b expected 0000", {false_start, timeout, busy, led_go}); end
  endtask

  task automatic test_delay_zero();
    int ks, g, er, ev, go_k, end_k;
    play(0, 9, ks, go_k, end_k, ev);
    g = ks + TD;
    er = diff(ms_at(go_k + 8), ms_at(g));
    n_checks++; if (go_k !== g) begin n_fail++; $display("FAIL zero_delay_go_time: got cycle %0d expected %0d", go_k, g); end
    n_checks++; if (result_ms !== er) begin n_fail++; $display("FAIL zero_delay_result: got %0d expected %0d", result_ms, er); end
  endtask

  task automatic test_start_during_go();
    int ks, g, go_k, e, er;
    do_start(2, ks);
    g = ks + TD * 2;
    go_k = -1;
    for (int i = 0; i < 1000 && go_k < 0; i++) begin
      if (led_go) go_k = cyc;
      else step();
    end
    start = 1'b1; delay_ms = W'(7);
    step();
    start = 1'b0;
    n_checks++; if ({led_go, busy} !== 2'b11) begin n_fail++; $display("FAIL start_in_go_ignored: got led/busy %b expected 11", {led_go, busy}); end
    button = 1'b1;
    e = cyc + 1;
    step(); step();
    button = 1'b0;
    er = diff(ms_at(e - 1), ms_at(g));
    n_checks++; if (result_valid !== 1'b1 || result_ms !== er) begin
      n_fail++; $display("FAIL start_in_go_result: got valid=%0d r=%0d expected valid=1 r=%0d", result_valid, result_ms, er); end
  endtask

  task automatic test_random();
    int d, p, ks, g, go_k, end_k, ev, ex, er;
    for (int r = 0; r < 8; r++) begin
      d = $urandom_range(0, 15);
      p = $urandom_range(1, 4 * MAXMS);
      play(d, p, ks, go_k, end_k, ev);
      g = ks + TD * dly(d);
      ex = ms_at(go_k + p - 1);
      er = diff(ex, ms_at(g));
      n_checks++; if (go_k !== g) begin n_fail++; $display("FAIL rand%0d_go_time: got %0d expected %0d (d=%0d)", r, go_k, g, d); end
      n_checks++; if (sub_x !== ex) begin n_fail++; $display("FAIL rand%0d_sub_x: got %0d expected %0d", r, sub_x, ex); end
      n_checks++; if (result_ms !== er) begin n_fail++; $display("FAIL rand%0d_result: got %0d expected %0d (p=%0d)", r, result_ms, er, p); end
      n_checks++; if ({result_valid, timeout, false_start} !== 3'b100) begin n_fail++; $display("FAIL rand%0d_flags: got %b expected 100", r, {result_valid, timeout, false_start}); end
    end
  endtask

  task automatic test_false_start();
    int ks, seen_go;
    do_start(50, ks);
    seen_go = 0;
    while (cyc < ks + 10 * TD) begin
      step();
      if (led_go) seen_go = 1;
    end
    button = 1'b1;
    step();
    n_checks++; if ({false_start, result_valid, busy, led_go} !== 4'b1000 || seen_go != 0) begin
      n_fail++; $display("FAIL false_start: got fs/valid/busy/led %b go_seen=%0d expected 1000 go_seen=0", {false_start, result_valid, busy, led_go}, seen_go); end
    // Button held across the start cycle: start accepted, then false start
    do_start(5, ks);
    n_checks++; if ({busy, false_start} !== 2'b10) begin n_fail++; $display("FAIL held_button_start: got busy/fs %b expected 10", {busy, false_start}); end
    step();
    n_checks++; if ({busy, false_start} !== 2'b01) begin n_fail++; $display("FAIL held_button_fs: got busy/fs %b expected 01", {busy, false_start}); end
    button = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int ks, go_k, end_k, ev;
    play(1, 0, ks, go_k, end_k, ev);
    n_checks++; if (end_k !== ks + TD + TD * MAXMS) begin n_fail++; $display("FAIL timeout_time: got cycle %0d expected %0d", end_k, ks + TD + TD * MAXMS); end
    n_checks++; if ({timeout, result_valid, led_go, busy} !== 4'b1000) begin n_fail++; $display("FAIL timeout_flags: got %b expected 1000", {timeout, result_valid, led_go, busy}); end
    n_checks++; if (result_ms !== MAXMS) begin n_fail++; $display("FAIL timeout_result: got %0d expected %0d", result_ms, MAXMS); end
    do_start(5, ks);
    n_checks++; if ({timeout, false_start, busy} !== 3'b001 || result_ms !== 0) begin
      n_fail++; $display("FAIL restart_clear: got to/fs/busy %b r=%0d expected 001 r=0", {timeout, false_start, busy}, result_ms); end
    button = 1'b1; step(); button = 1'b0; step();
  endtask

  task automatic test_press_at_timeout();
    int ks, go_k, end_k, ev, er;
    play(1, 4 * MAXMS, ks, go_k, end_k, ev);
    er = diff(ms_at(go_k + 4 * MAXMS - 1), ms_at(ks + TD));
    n_checks++; if ({result_valid, timeout} !== 2'b10 || result_ms !== er) begin
      n_fail++; $display("FAIL press_vs_timeout: got valid/to %b r=%0d expected 10 r=%0d", {result_valid, timeout}, result_ms, er); end
  endtask

  task automatic test_overflow();
    int ks, go_k, end_k, ev, ex, ey, eo;
    wait_ms(MOD / 2 - 6);
    play(2, 81, ks, go_k, end_k, ev);
    ey = ms_at(ks + 2 * TD); ex = ms_at(go_k + 80); eo = ovf_model(ex, ey);
    n_checks++; if (ovf_flag !== eo[0] || result_ms !== diff(ex, ey)) begin
      n_fail++; $display("FAIL overflow_capture: got ovf=%0d r=%0d expected ovf=%0d r=%0d", ovf_flag, result_ms, eo, diff(ex, ey)); end
    do_start(3, ks);
    n_checks++; if ({ovf_flag, result_valid} !== 2'b00) begin n_fail++; $display("FAIL overflow_clear: got ovf/valid %b expected 00", {ovf_flag, result_valid}); end
    button = 1'b1; step(); button = 1'b0; step();
  endtask

  task automatic test_wrap();
    int ks, go_k, end_k, ev, ex, ey;
    wait_ms(MOD - 7);
    play(2, 81, ks, go_k, end_k, ev);
    ey = ms_at(ks + 2 * TD); ex = ms_at(go_k + 80);
    n_checks++; if (sub_y !== ey) begin n_fail++; $display("FAIL wrap_sub_y: got %0d expected %0d", sub_y, ey); end
    n_checks++; if (sub_x !== ex) begin n_fail++; $display("FAIL wrap_sub_x: got %0d expected %0d", sub_x, ex); end
    n_checks++; if (result_ms !== diff(ex, ey) || result_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_result: got %0d valid=%0d expected %0d valid=1", result_ms, result_valid, diff(ex, ey)); end
  endtask

  task automatic test_reset_mid_go();
    int ks, go_k, end_k, ev, ey, er;
    do_start(4, ks);
    for (int i = 0; i < 1000 && !led_go; i++) step();
    reset_n = 1'b0;
    #1;
    n_checks++; if ({led_go, busy, result_valid, sub_addsub} !== 4'b0001) begin
      n_fail++; $display("FAIL async_reset: got led/busy/valid/addsub %b expected 0001", {led_go, busy, result_valid, sub_addsub}); end
    step();
    reset_n = 1'b1;
    cyc = 0; base_k = 0; base_ts = 0;
    n_checks++; if ({busy, result_ms} !== '0) begin n_fail++; $display("FAIL reset_idle: got busy=%0d r=%0d expected 0 0", busy, result_ms); end
    play(2, 5, ks, go_k, end_k, ev);
    ey = ms_at(ks + 2 * TD); er = diff(ms_at(go_k + 4), ey);
    n_checks++; if (sub_y !== ey || result_ms !== er) begin
      n_fail++; $display("FAIL ts_restart: got y=%0d r=%0d expected y=%0d r=%0d", sub_y, result_ms, ey, er); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_delay_zero();
    test_start_during_go();
    test_random();
    test_false_start();
    test_timeout();
    test_press_at_timeout();
    test_overflow();
    test_wrap();
    test_reset_mid_go();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
